psola_playback: RTL
===================

Name: psola_playback

Overview:
- Downstream consumer of the PSOLA resynthesis stage.
- When a frame completes (window length + valid), it reads the accumulated fixed-point buffer from address 0 to len-1, then writes zero back to each address so the next frame accumulates from a clean buffer.
- Each sample is rescaled by the window gain (rounded shift right by FRAC_BITS) and saturated.
- Samples are buffered in a small FIFO and emitted one per audio-rate sample tick to the DAC/I2S path.

Parameters:
- WINDOW_SIZE, 2048: buffer depth in samples; address width AW = $clog2(WINDOW_SIZE)+1.
- SAMPLE_WIDTH, 16: signed output sample width.
- FRAC_BITS, 10: window-function fixed-point fraction bits to remove.
- FIFO_DEPTH, 8: output FIFO entries (power of two, >=4).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- window_len_in  in  12  frame length in samples from the PSOLA stage
- window_len_valid_in  in  1  one-cycle strobe: frame complete, window_len_in valid
- sample_tick_in  in  1  one-cycle audio-rate strobe (e.g. 48 kHz)
- buf_rd_addr_out  out  AW  buffer read address
- buf_rd_data_in  in  32  signed buffer data, valid 2 cycles after address
- buf_clr_addr_out  out  AW  buffer clear-write address
- buf_clr_we_out  out  1  clear-write enable (write data is 0)
- audio_out  out  SAMPLE_WIDTH  signed output sample
- audio_valid_out  out  1  one-cycle pulse, one per sample_tick_in
- busy_out  out  1  frame playback in progress
- frame_done_out  out  1  one-cycle pulse when the last sample of a frame is popped
- frame_drop_out  out  1  one-cycle pulse when window_len_valid_in is ignored
- underrun_out  out  1  sticky; set when a tick finds the FIFO empty while busy

Behaviour:
- Reset (rst_in=0, async): all outputs 0, FSM=IDLE, FIFO empty, counters 0, in-flight pipe cleared.
- FSM states IDLE, FETCH, DRAIN.
- IDLE:
  - On window_len_valid_in, latch len = min(window_len_in, WINDOW_SIZE).
  - len=0: stay IDLE, no pulses.
  - Otherwise: go to FETCH, rd_ptr=0, busy_out=1 from the next cycle.
- FETCH:
  - Issue condition: fifo_count + inflight < FIFO_DEPTH, where inflight counts reads issued but not yet returned (0..2).
  - When met: drive buf_rd_addr_out = rd_ptr and increment rd_ptr.
  - After issuing address len-1, go to DRAIN.
  - A read issued in cycle t returns in t+2. In cycle t+2: push the converted sample, buf_clr_we_out=1, buf_clr_addr_out = address of cycle t. The clear follows the read, so the same address never sees a read/write collision.
- DRAIN:
  - Remaining returns are pushed and cleared as above.
  - Leave DRAIN when inflight=0 and FIFO is empty and the last sample has been popped: frame_done_out pulses, busy_out falls, go to IDLE.
- Conversion:
  - r = d + 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS (round half up).
  - Saturate to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - Example: 0x7FFFFFFF -> 32767; -1024 -> -1; 512 -> 1; 511 -> 0.
- Output, on every sample_tick_in:
  - audio_valid_out pulses the next cycle.
  - FIFO non-empty: pop, audio_out = head.
  - FIFO empty and busy: audio_out=0, underrun_out set sticky (cleared only by reset).
  - FIFO empty and not busy: audio_out=0 (silence), no underrun.
- Push and pop in the same cycle: both occur, fifo_count unchanged. A push never overflows, guaranteed by the issue rule.
- window_len_valid_in while busy: ignored, frame_drop_out pulses 1 cycle, the current frame is unaffected.
- window_len_valid_in in the same cycle as frame_done: treated as busy -> dropped.
- Throughput: FIFO fills within FIFO_DEPTH+2 cycles of frame start. Clear writes complete no later than the frame_done pulse.

Test Plan:
- Buffer preloaded with addr k = k<<10, len=5, ticks every 20 cycles -> audio_out 0,1,2,3,4 on successive ticks; frame_done after the 5th pop; addrs 0..4 cleared to 0 in the buffer model.
- Rounding/saturation: data 511, 512, -1024, 0x7FFFFFFF, 0x80000000 -> 0, 1, -1, 32767, -32768.
- Ticks every cycle (faster than fill), len=16 -> underrun_out=1 with at least one 0 sample emitted mid-frame; all 16 samples still emitted in order.
- window_len_valid_in with len=8, then again at cycle 3 with len=4 -> frame_drop_out pulse; exactly 8 samples played.
- len=0 strobe -> busy_out stays 0, no reads, no clears; len=3000 -> clamped to 2048 reads.
- rst_in low mid-FETCH (len=100, 10 samples out) -> outputs 0 immediately; after release, idle silence with audio_valid_out per tick and underrun_out=0.

Source files
------------

// File: rtl/psola_playback.sv
// Small FIFO with an occupancy count.
// Latency: one cycle from push to head visible.
// Backpressure: none internal; the caller never pushes when full and never pops when empty.
module fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;

    assign empty  = (count == '0);
    assign pop    = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (wr_vld) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({wr_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Plays a finished PSOLA frame: reads, rescales and clears the accumulation buffer, one sample per tick.
// Latency: buffer read returns 2 cycles after issue; sample appears the cycle after its tick.
// Backpressure: reads are only issued while FIFO entries plus in-flight reads fit in the FIFO.
module psola_playback #(
    parameter int WINDOW_SIZE  = 2048,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAC_BITS    = 10,
    parameter int FIFO_DEPTH   = 8,
    parameter int AW           = $clog2(WINDOW_SIZE) + 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [11:0]             window_len_in,
    input  logic                    window_len_valid_in,
    input  logic                    sample_tick_in,
    output logic [AW-1:0]           buf_rd_addr_out,
    input  logic [31:0]             buf_rd_data_in,
    output logic [AW-1:0]           buf_clr_addr_out,
    output logic                    buf_clr_we_out,
    output logic [SAMPLE_WIDTH-1:0] audio_out,
    output logic                    audio_valid_out,
    output logic                    busy_out,
    output logic                    frame_done_out,
    output logic                    frame_drop_out,
    output logic                    underrun_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [32:0] RND     = 33'sd1 <<< (FRAC_BITS - 1);
    localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (SAMPLE_WIDTH - 1)) - 33'sd1;
    localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (SAMPLE_WIDTH - 1));

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           len_q, rd_ptr_q, len_clamped;
    logic                    v1_q, v2_q;
    logic [AW-1:0]           a1_q, a2_q;
    logic [1:0]              inflight;
    logic                    issue, start, pop, frame_done;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty;
    logic [SAMPLE_WIDTH-1:0] fifo_head;
    logic signed [32:0]      rounded;
    logic [SAMPLE_WIDTH-1:0] sat_dat;

    assign len_clamped = (int'(window_len_in) > WINDOW_SIZE) ? AW'(WINDOW_SIZE) : AW'(window_len_in);
    assign start       = (state_q == IDLE) && window_len_valid_in && (len_clamped != '0);
    assign inflight    = {1'b0, v1_q} + {1'b0, v2_q};
    assign issue       = (state_q == FETCH) && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
    assign pop         = sample_tick_in && !fifo_empty;

    assign busy_out         = (state_q != IDLE);
    assign frame_done_out   = frame_done;
    assign buf_rd_addr_out  = issue ? rd_ptr_q : '0;
    // The clear trails the read by two cycles, so it lands on the address whose data is being pushed now.
    assign buf_clr_we_out   = v2_q;
    assign buf_clr_addr_out = v2_q ? a2_q : '0;

    always_comb begin
        rounded = ($signed({buf_rd_data_in[31], buf_rd_data_in}) + RND) >>> FRAC_BITS;
        sat_dat = rounded[SAMPLE_WIDTH-1:0];
        if (rounded > SAT_MAX)      sat_dat = SAT_MAX[SAMPLE_WIDTH-1:0];
        else if (rounded < SAT_MIN) sat_dat = SAT_MIN[SAMPLE_WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: if (issue && (rd_ptr_q == len_q - 1'b1)) state_d = DRAIN;
            DRAIN: begin
                if (!v1_q && !v2_q && fifo_empty) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            len_q           <= '0;
            rd_ptr_q        <= '0;
            v1_q            <= 1'b0;
            v2_q            <= 1'b0;
            a1_q            <= '0;
            a2_q            <= '0;
            frame_drop_out  <= 1'b0;
            audio_out       <= '0;
            audio_valid_out <= 1'b0;
            underrun_out    <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_drop_out <= window_len_valid_in && (state_q != IDLE);
            if (start) begin
                len_q    <= len_clamped;
                rd_ptr_q <= '0;
            end else if (issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            v1_q <= issue;
            a1_q <= rd_ptr_q;
            v2_q <= v1_q;
            a2_q <= a1_q;
            audio_valid_out <= sample_tick_in;
            if (sample_tick_in) begin
                audio_out <= fifo_empty ? '0 : fifo_head;
                if (fifo_empty && busy_out) underrun_out <= 1'b1;
            end
        end
    end

    fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .wr_vld (v2_q),
        .wr_dat (sat_dat),
        .rd_rdy (pop),
        .rd_dat (fifo_head),
        .count  (fifo_count),
        .empty  (fifo_empty)
    );
endmodule
